// File: rtl/riscboy_dispctrl_frame_seq_pkg.sv
// Shared constants for the per-frame LCD sequencer: panel opcodes, state encoding
// and the opcode lookup by command index.
package riscboy_dispctrl_frame_seq_pkg;

  localparam logic [7:0] LCD_CASET = 8'h2A;
  localparam logic [7:0] LCD_RASET = 8'h2B;
  localparam logic [7:0] LCD_RAMWR = 8'h2C;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_SETTLE_CS  = 3'd1;
  localparam state_t ST_CMD        = 3'd2;
  localparam state_t ST_SETTLE_DC  = 3'd3;
  localparam state_t ST_ARGS       = 3'd4;
  localparam state_t ST_SETTLE_ARG = 3'd5;
  localparam state_t ST_SCAN       = 3'd6;
  localparam state_t ST_FINISH     = 3'd7;

  function automatic logic [7:0] lcd_opcode(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CASET;
      2'd1:    return LCD_RASET;
      default: return LCD_RAMWR;
    endcase
  endfunction

endpackage

// File: rtl/riscboy_dispctrl_frame_seq_if.sv
// Pixel-FIFO write port, shifter status and LCD control lines shared between the
// frame sequencer (master) and the display-controller datapath (slave).
interface riscboy_dispctrl_frame_seq_if;
  logic [15:0] pxfifo_wdata;
  logic        pxfifo_wen;
  logic        pxfifo_full;
  logic        pxfifo_empty;
  logic        tx_busy;
  logic        scanout_buf_release;
  logic        lcd_cs;
  logic        lcd_dc;
  logic        lcd_shiftcnt;
  logic        scan_en;

  modport master (
    output pxfifo_wdata, pxfifo_wen, lcd_cs, lcd_dc, lcd_shiftcnt, scan_en,
    input  pxfifo_full, pxfifo_empty, tx_busy, scanout_buf_release
  );

  modport slave (
    input  pxfifo_wdata, pxfifo_wen, lcd_cs, lcd_dc, lcd_shiftcnt, scan_en,
    output pxfifo_full, pxfifo_empty, tx_busy, scanout_buf_release
  );
endinterface

// File: rtl/riscboy_dispctrl_idle_settle.sv
// Counts consecutive cycles with the FIFO empty and the shifter idle; "settled"
// once that run reaches SETTLE_CYCLES, so CS/DC/width changes never hit live bits.
module riscboy_dispctrl_idle_settle #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic fifo_empty,
  input  logic tx_busy,
  output logic settled
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push || !fifo_empty || tx_busy) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign settled = (cnt >= CNT_MAX);

endmodule

// File: rtl/riscboy_dispctrl_frame_seq.sv
// Per-frame sequencer: sends CASET/RASET/RAMWR with window arguments as byte pushes,
// steers CS/DC/shift width at settled points, then runs scanout for cfg_lines buffers.
module riscboy_dispctrl_frame_seq
  import riscboy_dispctrl_frame_seq_pkg::*;
#(
  parameter int W_COORD       = 9,
  parameter int W_LINES       = 9,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [W_COORD-1:0] cfg_x0,
  input  logic [W_COORD-1:0] cfg_x1,
  input  logic [W_COORD-1:0] cfg_y0,
  input  logic [W_COORD-1:0] cfg_y1,
  input  logic [W_LINES-1:0] cfg_lines,
  output logic               busy,
  output logic               done,
  riscboy_dispctrl_frame_seq_if.master lcd
);

  state_t             state, state_nxt;
  logic [1:0]         idx, idx_nxt;
  logic [1:0]         bcnt, bcnt_nxt;
  logic [W_LINES-1:0] rel_cnt, rel_nxt, rel_inc;
  logic               cs, cs_nxt, dc, dc_nxt, shift, shift_nxt;
  logic               done_pulse, done_nxt;
  logic               capture;
  logic [W_COORD-1:0] x0, x1, y0, y1;
  logic [W_LINES-1:0] lines;
  logic               settled;
  logic               wen;
  logic [7:0]         wbyte;
  logic [15:0]        a0, a1;
  logic [7:0]         arg_byte;

  riscboy_dispctrl_idle_settle #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk        (clk),
    .rst        (rst),
    .push       (wen),
    .fifo_empty (lcd.pxfifo_empty),
    .tx_busy    (lcd.tx_busy),
    .settled    (settled)
  );

  // State and control registers; captured window is data and carries no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      bcnt       <= '0;
      rel_cnt    <= '0;
      cs         <= 1'b1;
      dc         <= 1'b0;
      shift      <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      bcnt       <= bcnt_nxt;
      rel_cnt    <= rel_nxt;
      cs         <= cs_nxt;
      dc         <= dc_nxt;
      shift      <= shift_nxt;
      done_pulse <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      x0    <= cfg_x0;
      x1    <= cfg_x1;
      y0    <= cfg_y0;
      y1    <= cfg_y1;
      lines <= cfg_lines;
    end
  end

  assign rel_inc = rel_cnt + W_LINES'(1);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bcnt_nxt  = bcnt;
    rel_nxt   = rel_cnt;
    cs_nxt    = cs;
    dc_nxt    = dc;
    shift_nxt = shift;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        capture   = 1'b1;
        idx_nxt   = '0;
        bcnt_nxt  = '0;
        rel_nxt   = '0;
        state_nxt = ST_SETTLE_CS;
      end
      ST_SETTLE_CS: if (settled) begin
        cs_nxt    = 1'b0;
        dc_nxt    = 1'b0;
        state_nxt = ST_CMD;
      end
      ST_CMD: if (wen) state_nxt = ST_SETTLE_DC;
      ST_SETTLE_DC: if (settled) begin
        dc_nxt = 1'b1;
        if (idx != 2'd2) begin
          bcnt_nxt  = '0;
          state_nxt = ST_ARGS;
        end else begin
          shift_nxt = 1'b1;
          state_nxt = (lines == '0) ? ST_FINISH : ST_SCAN;
        end
      end
      ST_ARGS: if (wen) begin
        bcnt_nxt = bcnt + 2'd1;
        if (bcnt == 2'd3) state_nxt = ST_SETTLE_ARG;
      end
      ST_SETTLE_ARG: if (settled) begin
        dc_nxt    = 1'b0;
        idx_nxt   = idx + 2'd1;
        state_nxt = ST_CMD;
      end
      ST_SCAN: if (lcd.scanout_buf_release) begin
        if (rel_cnt != lines) rel_nxt = rel_inc;
        if (rel_inc == lines) state_nxt = ST_FINISH;
      end
      ST_FINISH: if (settled) begin
        cs_nxt    = 1'b1;
        dc_nxt    = 1'b0;
        shift_nxt = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE && state != ST_FINISH) state_nxt = ST_FINISH;
  end

  always_comb begin
    a0 = (idx == 2'd0) ? 16'(x0) : 16'(y0);
    a1 = (idx == 2'd0) ? 16'(x1) : 16'(y1);
    case (bcnt)
      2'd0:    arg_byte = a0[15:8];
      2'd1:    arg_byte = a0[7:0];
      2'd2:    arg_byte = a1[15:8];
      default: arg_byte = a1[7:0];
    endcase
  end

  // Pushes are combinational on !full so a write is never presented into a full FIFO
  always_comb begin
    wen   = 1'b0;
    wbyte = 8'h00;
    if (state == ST_CMD) begin
      wen   = !lcd.pxfifo_full;
      wbyte = lcd_opcode(idx);
    end else if (state == ST_ARGS) begin
      wen   = !lcd.pxfifo_full;
      wbyte = arg_byte;
    end
    lcd.pxfifo_wen    = wen;
    lcd.pxfifo_wdata  = wen ? {wbyte, 8'h00} : 16'h0000;
    lcd.scan_en       = (state == ST_SCAN);
    lcd.lcd_cs        = cs;
    lcd.lcd_dc        = dc;
    lcd.lcd_shiftcnt  = shift;
    busy              = (state != ST_IDLE);
    done              = done_pulse;
  end

endmodule

// File: tb/tb_riscboy_dispctrl_frame_seq.sv
// Scoreboard bench for the frame sequencer: expected FIFO words queued at start,
// popped on every write strobe; LCD control changes checked against a settle model.
`timescale 1ns/1ps
module tb_riscboy_dispctrl_frame_seq;
  localparam int W_COORD = 9;
  localparam int W_LINES = 9;
  localparam int SETTLE  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [W_COORD-1:0] cfg_x0 = '0, cfg_x1 = '0, cfg_y0 = '0, cfg_y1 = '0;
  logic [W_LINES-1:0] cfg_lines = '0;
  logic               busy, done;

  riscboy_dispctrl_frame_seq_if lcd();

  riscboy_dispctrl_frame_seq #(
    .W_COORD(W_COORD), .W_LINES(W_LINES), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .cfg_lines(cfg_lines), .busy(busy), .done(done), .lcd(lcd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pops and an independent settle-counter model
  int          mcnt = 0;
  int          scan_cycles = 0;
  logic        settled_prev = 1'b0;
  logic        rst_prev = 1'b1;
  logic [2:0]  ctl_prev = 3'b100;

  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_prev && {lcd.lcd_cs, lcd.lcd_dc, lcd.lcd_shiftcnt} != ctl_prev)
      chk("ctl_change_when_settled", settled_prev, 1'b1);
    if (lcd.pxfifo_wen) begin
      chk("wen_while_full", lcd.pxfifo_full, 1'b0);
      if (sb.size() != 0) e = sb.pop_front();
      else e = 17'h1_FFFF;
      chk("push_data", lcd.pxfifo_wdata, e[15:0]);
      chk("push_dc", lcd.lcd_dc, e[16]);
    end
    if (lcd.scan_en) scan_cycles++;
    settled_prev = (mcnt >= SETTLE);
    if (rst || lcd.pxfifo_wen || !lcd.pxfifo_empty || lcd.tx_busy) mcnt = 0;
    else if (mcnt < SETTLE) mcnt++;
    ctl_prev = {lcd.lcd_cs, lcd.lcd_dc, lcd.lcd_shiftcnt};
    rst_prev = rst;
  end

  task automatic chk_reset(input string tag);
    chk(tag, {busy, done, lcd.pxfifo_wen, lcd.pxfifo_wdata, lcd.lcd_cs, lcd.lcd_dc,
              lcd.lcd_shiftcnt, lcd.scan_en},
        {1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic push_word(input logic [W_COORD-1:0] v);
    logic [15:0] w;
    w = 16'(v);
    sb.push_back({1'b1, w[15:8], 8'h00});
    sb.push_back({1'b1, w[7:0], 8'h00});
  endtask

  task automatic start_frame(input logic [W_COORD-1:0] x0, x1, y0, y1,
                             input logic [W_LINES-1:0] lines, input bit with_abort);
    sb.push_back({1'b0, 8'h2A, 8'h00});
    push_word(x0); push_word(x1);
    sb.push_back({1'b0, 8'h2B, 8'h00});
    push_word(y0); push_word(y1);
    sb.push_back({1'b0, 8'h2C, 8'h00});
    @(posedge clk); #1;
    cfg_x0 = x0; cfg_x1 = x1; cfg_y0 = y0; cfg_y1 = y1; cfg_lines = lines;
    start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    cfg_x0 = ~x0; cfg_x1 = ~x1; cfg_y0 = ~y0; cfg_y1 = ~y1; cfg_lines = lines + 9'd5;
  endtask

  task automatic wait_scan(input string tag);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (lcd.scan_en) break;
    end
    chk(tag, lcd.scan_en, 1'b1);
  endtask

  task automatic release_pulse();
    @(posedge clk); #1 lcd.scanout_buf_release = 1'b1;
    @(posedge clk); #1 lcd.scanout_buf_release = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_end_ctl"}, {busy, lcd.lcd_cs, lcd.lcd_dc, lcd.lcd_shiftcnt, lcd.scan_en},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    int stall_wen, dc_early, scan_before;
    lcd.pxfifo_full = 1'b0;
    lcd.pxfifo_empty = 1'b1;
    lcd.tx_busy = 1'b0;
    lcd.scanout_buf_release = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_state");
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);

    // Frame 1: full window, 128 lines
    start_frame(9'd0, 9'd159, 9'd0, 9'd127, 9'd128, 1'b0);
    wait_scan("f1_scan_start");
    chk("f1_cmds_sent", sb.size(), 0);
    chk("f1_scan_ctl", {lcd.lcd_cs, lcd.lcd_dc, lcd.lcd_shiftcnt}, 3'b011);
    for (int i = 0; i < 127; i++) release_pulse();
    @(negedge clk);
    chk("f1_scan_before_last", lcd.scan_en, 1'b1);
    release_pulse();
    @(negedge clk);
    chk("f1_scan_after_last", lcd.scan_en, 1'b0);
    wait_done("f1");

    // Frame 2: stall mid-ARGS, no scan phase
    scan_before = scan_cycles;
    start_frame(9'd3, 9'h1AB, 9'h100, 9'h0FF, 9'd0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (sb.size() <= 9) break;
    end
    #1 lcd.pxfifo_full = 1'b1;
    stall_wen = 0;
    repeat (10) begin
      @(negedge clk);
      if (lcd.pxfifo_wen) stall_wen++;
    end
    chk("f2_stall_wen", stall_wen, 0);
    chk("f2_stall_held", sb.size(), 9);
    @(posedge clk); #1 lcd.pxfifo_full = 1'b0;
    wait_done("f2");
    chk("f2_no_scan", scan_cycles - scan_before, 0);

    // Frame 3: shifter busy after CASET delays DC
    start_frame(9'd10, 9'd20, 9'd30, 9'd40, 9'd2, 1'b0);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (sb.size() <= 10) break;
    end
    #1 lcd.tx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 lcd.tx_busy = 1'b0;
    dc_early = 0;
    repeat (5) begin
      @(negedge clk);
      if (lcd.lcd_dc) dc_early++;
    end
    chk("f3_dc_held", dc_early, 0);
    @(negedge clk);
    chk("f3_dc_rise", lcd.lcd_dc, 1'b1);
    wait_scan("f3_scan_start");
    release_pulse();
    release_pulse();
    wait_done("f3");

    // Frame 4: start ignored while busy, then abort in SCAN after 5 releases
    start_frame(9'd0, 9'd15, 9'd0, 9'd15, 9'd20, 1'b0);
    wait_scan("f4_scan_start");
    repeat (5) release_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("f4_busy_start_ignored", {busy, lcd.scan_en}, 2'b11);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("f4_scan_off_after_abort", lcd.scan_en, 1'b0);
    wait_done("f4");

    // Frame 5: start+abort together in IDLE, then reset during SCAN
    start_frame(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 9'd10, 1'b1);
    @(negedge clk);
    chk("f5_start_taken", busy, 1'b1);
    wait_scan("f5_scan_start");
    release_pulse();
    release_pulse();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("f5_reset_mid_scan");

    // Frame 6: recovery after reset, single line
    repeat (6) @(posedge clk);
    start_frame(9'd1, 9'd2, 9'd3, 9'd4, 9'd1, 1'b0);
    wait_scan("f6_scan_start");
    release_pulse();
    wait_done("f6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/riscboy_dispctrl_frame_seq.md
Name: riscboy_dispctrl_frame_seq

Overview:
- Per-frame sequencer for the PPU display controller, running in the system clock domain.
- On a start request it issues the LCD window-set command stream (CASET, RASET, RAMWR plus arguments) as 8-bit direct pixel-FIFO writes, manages CS/DC/shift-width, then enables scanout and counts scanbuf releases until the frame completes.
- Removes per-frame CPU byte-banging. It sits beside the dispctrl register block and overrides its control fields while busy.

Parameters:
- W_COORD, 9, width of window coordinates.
- W_LINES, 9, width of the scanbuf-release counter.
- SETTLE_CYCLES, 4, consecutive idle cycles required before CS/DC/shift-width may change (covers the CDC lag on tx_busy).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin a frame; ignored while busy
- abort  in  1  pulse: terminate the current frame
- cfg_x0, cfg_x1, cfg_y0, cfg_y1  in  W_COORD each  window bounds, inclusive
- cfg_lines  in  W_LINES  number of scanbuf releases per frame; 0 means no scan phase
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at completion or abort
- pxfifo_wdata  out  16  direct write data
- pxfifo_wen  out  1  direct write strobe
- pxfifo_full  in  1  pixel FIFO full (write side)
- pxfifo_empty  in  1  pixel FIFO empty (write side)
- tx_busy  in  1  shifter busy, already synchronised to clk
- scanout_buf_release  in  1  pulse per scanbuf line consumed
- lcd_cs  out  1  chip select to shifter, active low
- lcd_dc  out  1  data/command select
- lcd_shiftcnt  out  1  0 = 8-bit, 1 = 16-bit per FIFO entry
- scan_en  out  1  enables PPU scanout into the FIFO

Behaviour:
- Reset values: busy=0, done=0, pxfifo_wen=0, pxfifo_wdata=0, lcd_cs=1, lcd_dc=0, lcd_shiftcnt=0, scan_en=0; state IDLE.
- Window config is captured on the start cycle. Changes to cfg_* while busy have no effect.
- Byte push: pxfifo_wdata={byte,8'h00} with pxfifo_wen=1 for one cycle, only in a cycle where pxfifo_full=0. At most one push per cycle; the sequence stalls while full.
- Idle qualifier: settle counter counts consecutive cycles with pxfifo_empty && !tx_busy. It resets to 0 on any push or when either condition fails. "Settled" means count >= SETTLE_CYCLES.
- lcd_cs, lcd_dc and lcd_shiftcnt change only in a cycle where settled is true.
- IDLE: on start, set busy=1 and go to SETTLE_CS.
- SETTLE_CS: when settled, set lcd_cs=0 and lcd_dc=0, then go to CMD(idx=0).
- CMD(idx): push the opcode (idx0=0x2A, idx1=0x2B, idx2=0x2C), then go to SETTLE_DC.
- SETTLE_DC: when settled, set lcd_dc=1.
  - idx<2: go to ARGS.
  - idx==2: set lcd_shiftcnt=1 and go to SCAN, or to FINISH if cfg_lines==0.
- ARGS: push 4 bytes: a0[15:8], a0[7:0], a1[15:8], a1[7:0].
  - a=x for idx0, y for idx1; each coordinate is zero-extended to 16 bits.
  - Then wait until settled, set lcd_dc=0, increment idx, go to CMD.
- SCAN: scan_en=1. Count scanout_buf_release pulses; when count reaches cfg_lines, deassert scan_en in the same cycle as the final release and go to FINISH.
- FINISH: when settled, set lcd_cs=1, lcd_shiftcnt=0, lcd_dc=0, busy=0, pulse done, go to IDLE.
- abort in any non-IDLE state: scan_en=0 next cycle, no further pushes, go to FINISH. A push already presented in the abort cycle still completes.
- start and abort in the same cycle while IDLE: start is taken; abort is ignored.
- rst asserted mid-frame returns all outputs to reset values on the next edge. The sequencer does not drain the FIFO in that case.
- Release counter wraps never: it saturates at cfg_lines.

Decomposition:
- Shared package holds the LCD opcode constants (CASET=8'h2A, RASET=8'h2B, RAMWR=8'h2C) and the state encoding localparams.
- One sub-module: riscboy_dispctrl_idle_settle, the settle counter/qualifier, reusable by the software-driven path.

Test Plan:
- Window (0,0)-(159,127), cfg_lines=128, FIFO never full → push sequence 2A | 00 00 00 9F | 2B | 00 00 00 7F | 2C, all as {byte,00}. DC is low only on the opcodes. scan_en rises after RAMWR settles. done pulses after the 128th release and settle; cs returns high.
- Hold pxfifo_full=1 for 10 cycles mid-ARGS → no wen during the stall, byte order unchanged, no bytes dropped.
- Hold tx_busy high for 3 cycles after a push with FIFO empty → DC does not toggle until SETTLE_CYCLES clean cycles have passed.
- abort during SCAN after 5 releases → scan_en=0 next cycle, no wen, done pulses after settle, cs=1, shiftcnt=0.
- cfg_lines=0 → scan_en is never asserted; done follows RAMWR settle.
- start while busy, and rst in SCAN → start is ignored; after rst all outputs equal reset values on the next edge.
